// File: rtl/spi_slave_param.sv
`default_nettype none
// ============================================================================
//  Module   : spi_slave_param
//  Purpose  : Parametrised SPI slave front-end between the SPI pins and a
//             single-port RAM command port. Receives a 2-bit command plus
//             DATA_W-bit payload per frame and returns read data on MISO.
//             It also reports aborted frames and read-data timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter int MSB_FIRST  = 1,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic [2:0]        cs,
  output logic              frame_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CW      = $clog2(FRAME_W + 1);
  localparam int TCW     = $clog2(DATA_W + 1);

  localparam logic [CW-1:0]  c_FRAME   = CW'(FRAME_W);
  localparam logic [CW-1:0]  c_LAST    = CW'(FRAME_W - 1);
  localparam logic [TCW-1:0] c_TX_LEN  = TCW'(DATA_W);
  localparam logic [7:0]     c_TO_LAST = 8'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CW-1:0]        r_bitcnt;
  logic [FRAME_W-1:0]   r_frame;
  logic [FRAME_W-1:0]   w_frame_next;
  logic [CW-1:0]        w_pos;
  logic [FRAME_W-1:0]   r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  logic                 r_rd_seen;
  logic                 r_wait;
  logic [7:0]           r_to_cnt;
  logic [TCW-1:0]       r_tx_cnt;
  logic [DATA_W-1:0]    r_tx_sh;
  logic                 r_miso;

  logic                 w_rx_phase;
  logic                 w_last_bit;
  logic                 w_tx_out;
  logic                 w_abort;
  logic                 w_timeout;
  logic                 w_tx_first;
  logic [DATA_W-1:0]    w_tx_load;
  logic                 w_tx_bit;
  logic [DATA_W-1:0]    w_tx_shift;

  // Payload bit order only changes which end of the shift register feeds MISO.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_tx_first = tx_data[DATA_W-1];
      assign w_tx_load  = tx_data << 1;
      assign w_tx_bit   = r_tx_sh[DATA_W-1];
      assign w_tx_shift = r_tx_sh << 1;
    end else begin : g_lsb
      assign w_tx_first = tx_data[0];
      assign w_tx_load  = tx_data >> 1;
      assign w_tx_bit   = r_tx_sh[0];
      assign w_tx_shift = r_tx_sh >> 1;
    end
  endgenerate

  // Frame bits still to come (CHK_CMD counts as the first receive bit).
  assign w_rx_phase = (r_state != IDLE) && (r_bitcnt < c_FRAME);
  assign w_last_bit = w_rx_phase && !SS_n && (r_bitcnt == c_LAST);
  // A response bit other than the one currently on MISO is still owed.
  assign w_tx_out   = r_tx_cnt > TCW'(1);
  // Losing SS_n while a reply is pending or bits remain is an aborted frame.
  assign w_abort    = SS_n && (w_rx_phase || r_wait || w_tx_out);
  assign w_timeout  = !SS_n && r_wait && !tx_valid && (r_to_cnt == c_TO_LAST);

  // Map the running bit index onto its rx_data position and merge in MOSI.
  always_comb begin
    w_pos        = '0;
    w_frame_next = r_frame;
    if ((MSB_FIRST != 0) || (r_bitcnt < CW'(2))) begin
      w_pos = c_LAST - r_bitcnt;
    end else begin
      w_pos = r_bitcnt - CW'(2);
    end
    for (int i = 0; i < FRAME_W; i++) begin
      if (w_pos == CW'(i)) begin
        w_frame_next[i] = MOSI;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode: command bit chooses the branch, SS_n high ends the frame.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (!SS_n) w_next = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)           w_next = IDLE;
        else if (!MOSI)     w_next = WRITE;
        else if (r_rd_seen) w_next = READ_DATA;
        else                w_next = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Receive shifting, read-response transmit, timeout and error reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt    <= '0;
      r_frame     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_rd_seen   <= 1'b0;
      r_wait      <= 1'b0;
      r_to_cnt    <= '0;
      r_tx_cnt    <= '0;
      r_tx_sh     <= '0;
      r_miso      <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= w_abort || w_timeout;
      if (SS_n) begin
        // Deselect tears down any frame or response in progress.
        r_bitcnt <= '0;
        r_wait   <= 1'b0;
        r_to_cnt <= '0;
        r_tx_cnt <= '0;
        r_miso   <= 1'b0;
      end else begin
        if (w_rx_phase) begin
          r_frame  <= w_frame_next;
          r_bitcnt <= r_bitcnt + CW'(1);
          if (w_last_bit) begin
            r_rx_data  <= w_frame_next;
            r_rx_valid <= 1'b1;
            if (r_state == READ_ADD) begin
              r_rd_seen <= 1'b1;
            end
            if (r_state == READ_DATA) begin
              r_rd_seen <= 1'b0;
              r_wait    <= 1'b1;
              r_to_cnt  <= '0;
            end
          end
        end
        if (r_wait) begin
          if (tx_valid) begin
            // First payload bit goes out on the same edge tx_valid is seen.
            r_wait   <= 1'b0;
            r_miso   <= w_tx_first;
            r_tx_sh  <= w_tx_load;
            r_tx_cnt <= c_TX_LEN;
          end else if (r_to_cnt == c_TO_LAST) begin
            // Give up: no response for this frame, MISO stays low.
            r_wait <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + 8'd1;
          end
        end else if (r_tx_cnt != '0) begin
          r_miso   <= w_tx_out ? w_tx_bit : 1'b0;
          r_tx_sh  <= w_tx_shift;
          r_tx_cnt <= r_tx_cnt - TCW'(1);
        end
      end
    end
  end

  assign MISO      = r_miso;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign cs        = r_state;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave front-end sitting between the SPI serial pins and the single-port RAM command port. It generalises the fixed 10-bit SPI slave with:
- a configurable payload width and bit order;
- a read-data response timeout;
- explicit frame-error reporting.

It keeps the same command framing and the same five-state FSM, so the existing state-transition assertions carry over unchanged.

## Interface
- DATA_W, 8, payload width in bits; frame length FRAME_W = DATA_W+2.
- MSB_FIRST, 1, payload bit order on MOSI and MISO (1: MSB first, 0: LSB first); command bits are always sent first.
- TX_TIMEOUT, 16, maximum clk edges to wait for tx_valid in READ_DATA; legal range 1..255.
- clk  in  1  single clock; doubles as the SPI serial clock; all sampling on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  serial data in.
- tx_data  in  DATA_W  read data from RAM.
- tx_valid  in  1  tx_data valid; only honoured while waiting in READ_DATA.
- MISO  out  1  serial data out, registered.
- rx_data  out  DATA_W+2  received frame: [FRAME_W-1:FRAME_W-2] = command, [DATA_W-1:0] = payload.
- rx_valid  out  1  one-cycle pulse when a complete frame is in rx_data.
- cs  out  3  current state: IDLE=0, CHK_CMD=1, WRITE=2, READ_ADD=3, READ_DATA=4.
- frame_err  out  1  one-cycle pulse on an aborted frame or a tx timeout.

## Operation
- Reset: cs=IDLE, MISO=0, rx_data=0, rx_valid=0, frame_err=0. Reset also clears rd_addr_seen, the bit counter, the tx shift register and the timeout counter.
- Reset asserted mid-frame clears everything immediately; no rx_valid or frame_err is produced.
- FSM:
  - IDLE: SS_n=0 → CHK_CMD; otherwise stay.
  - CHK_CMD: SS_n=1 → IDLE. Otherwise MOSI=0 → WRITE; MOSI=1 with rd_addr_seen=0 → READ_ADD; MOSI=1 with rd_addr_seen=1 → READ_DATA.
  - WRITE, READ_ADD, READ_DATA: SS_n=1 → IDLE; otherwise stay.
- Receive path:
  - The MOSI bit sampled in CHK_CMD is frame bit 0 and becomes rx_data[FRAME_W-1].
  - The next FRAME_W-1 MOSI bits fill the remaining command bit, then the payload in MSB_FIRST order.
  - Bits after FRAME_W are ignored until SS_n rises.
- rd_addr_seen is set when a READ_ADD frame completes and cleared when a READ_DATA frame completes. Aborted frames leave it unchanged.
- READ_DATA response:
  - After rx_valid, the block waits for tx_valid=1.
  - On that edge it latches tx_data and shifts out DATA_W bits on MISO in MSB_FIRST order, then returns MISO to 0.
  - Only one response is sent per frame.
- Timeout: if TX_TIMEOUT edges pass in the wait phase with tx_valid=0, the block pulses frame_err once. It then sends no response (MISO=0) and stays in READ_DATA until SS_n=1.
- Abort: SS_n sampled high while receive bits or transmit bits are still outstanding pulses frame_err and returns the FSM to IDLE.
  - On a receive-phase abort, rx_valid is not pulsed and rx_data keeps its previous value.
- rx_data is stable from the rx_valid pulse until the next frame completes.

## Timing
- Edge numbering: edge 0 samples SS_n=0 in IDLE; edge 1 samples frame bit 0 in CHK_CMD; edge k samples bit k-1.
- Edge FRAME_W samples the last frame bit. rx_data updates and rx_valid=1 at that edge, and rx_valid drops at the next edge.
- READ_DATA transmit, with tx_valid sampled high at edge E ≥ FRAME_W+1:
  - the first payload bit appears on MISO at edge E;
  - bit j appears at edge E+j;
  - MISO returns to 0 at edge E+DATA_W.
- frame_err is asserted at the edge that detects the error and lasts exactly one cycle.
- The timeout counter starts at edge FRAME_W+1, and frame_err fires at edge FRAME_W+TX_TIMEOUT if tx_valid is never seen.
- SS_n=1 and the last receive bit on the same edge: the bit is not taken, and the edge counts as an abort.
- SS_n=1 at edge E+DATA_W, i.e. after the last MISO bit: normal completion, no error.

## Test plan
- Write address, DATA_W=8: frame bits 0,0 then payload 0xA5 MSB-first → rx_data=10'h0A5 with rx_valid at edge 10, cs=WRITE, no frame_err.
- Read sequence:
  - READ_ADD frame 1,0,0x3C → rx_data=10'h23C;
  - READ_DATA frame 1,1,0x00 → rx_data=10'h300;
  - then tx_valid with tx_data=0x96 at edge 12 → MISO 1,0,0,1,0,1,1,0 on edges 12–19, rd_addr_seen cleared.
- LSB-first (MSB_FIRST=0): write frame 0,1 with payload bits 1,0,0,0,0,0,0,0 → rx_data=10'h101.
- Abort: SS_n raised after 5 frame bits → frame_err pulse, no rx_valid, cs=IDLE next cycle; the next CHK_CMD after MOSI=1 still goes to READ_ADD.
- Timeout, TX_TIMEOUT=4: READ_DATA frame with tx_valid held 0 → frame_err at edge 14, MISO stays 0; a later tx_valid is ignored until SS_n=1.
- Async reset asserted at edge 6 of a write frame → all outputs 0 and cs=IDLE immediately; no rx_valid.
